bsg_then_ready_link_to_wide_link_db: RTL and testbench

Full-duplex endpoint between a narrow serial then_ready link and a wide ready_and link. Both directions are double-buffered, so a stalled wide consumer does not stall in-flight serial beats, and a new wide word is serialised with no bubble after the previous one. It is built from explicit beat counters and FSMs, not generic PISO/SIPO instances. It also provides wrap-around word counters for link bring-up debug.

---
 rtl/bsg_then_ready_link_to_wide_link_db.sv | 199 +++++++++++++++++++
 tb/tb_bsg_then_ready_link_to_wide_link_db.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_then_ready_link_to_wide_link_db.sv
// bsg_then_ready_link_to_wide_link_db
//
// Full-duplex endpoint between a narrow then_ready serial link and a wide
// ready_and link. Each direction is double-buffered:
//   RX (serial -> wide): beat assembly register feeding a 2-entry word FIFO.
//   TX (wide -> serial): ACTIVE/PENDING word slots feeding a beat serialiser.
// Beats are LSB-first; a wide word occupies R = ceil(W/N) beats, zero-padded.
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   wide_link_i  {v, data[W-1:0], ready_and_rev} from wide producer / consumer
//   wide_link_o  {v, data[W-1:0], ready_and_rev} to wide consumer / producer
//   bsg_link_i   {v, data[N-1:0], then_ready_rev} from serial sender / receiver
//   bsg_link_o   {v, data[N-1:0], then_ready_rev} to serial receiver / sender
//   rx_words_o   wrap-around count of wide words delivered
//   tx_words_o   wrap-around count of wide words fully serialised
module bsg_then_ready_link_to_wide_link_db #(
  parameter int wide_link_width_p = 64,
  parameter int bsg_link_width_p  = 16,
  parameter int counter_width_p   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [wide_link_width_p+1:0] wide_link_i,
  output logic [wide_link_width_p+1:0] wide_link_o,
  input  logic [bsg_link_width_p+1:0]  bsg_link_i,
  output logic [bsg_link_width_p+1:0]  bsg_link_o,
  output logic [counter_width_p-1:0]   rx_words_o,
  output logic [counter_width_p-1:0]   tx_words_o
);

  localparam int W  = wide_link_width_p;
  localparam int N  = bsg_link_width_p;
  localparam int R  = (W + N - 1) / N;
  localparam int RN = R * N;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  typedef enum logic [1:0] {TX_EMPTY, TX_ACTIVE, TX_BOTH} tx_state_e;

  // Input link fields
  logic         wide_in_v, wide_in_ready, bsg_in_v, peer_ready;
  logic [W-1:0] wide_in_data;
  logic [N-1:0] bsg_in_data;

  assign wide_in_v     = wide_link_i[W+1];
  assign wide_in_data  = wide_link_i[W:1];
  assign wide_in_ready = wide_link_i[0];
  assign bsg_in_v      = bsg_link_i[N+1];
  assign bsg_in_data   = bsg_link_i[N:1];
  assign peer_ready    = bsg_link_i[0];

  // State
  logic                       up_q, up_d;
  logic [CW-1:0]              rx_cnt_q, rx_cnt_d;
  logic [W-1:0]               fifo_q [2];
  logic [W-1:0]               fifo_d [2];
  logic                       fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [1:0]                 fifo_cnt_q, fifo_cnt_d;
  logic [counter_width_p-1:0] rx_words_q, rx_words_d;
  tx_state_e                  tx_state_q, tx_state_d;
  logic [RN-1:0]              active_q, active_d, pending_q, pending_d;
  logic [CW-1:0]              tx_cnt_q, tx_cnt_d;
  logic [counter_width_p-1:0] tx_words_q, tx_words_d;

  // RX control
  logic         rx_at_last, rx_ready, enq, deq;
  logic [W-1:0] enq_word;

  assign rx_at_last = (rx_cnt_q == LAST);
  // Only the final beat of a word needs FIFO space, so mid-word beats never
  // stall; no dependence on the wide consumer's ready within this cycle.
  assign rx_ready   = up_q & bsg_in_v & (~rx_at_last | (fifo_cnt_q != 2'd2));
  assign enq        = rx_ready & rx_at_last;
  assign deq        = (fifo_cnt_q != 2'd0) & wide_in_ready;

  // Assembly register holds beats 0..R-2; the last beat goes straight into
  // the FIFO with its pad bits dropped.
  if (R > 1) begin : g_asm
    localparam int AW = (R - 1) * N;
    localparam int LW = W - AW;
    logic [AW-1:0] rx_asm_q, rx_asm_d;

    always_comb begin
      rx_asm_d = rx_asm_q;
      if (rx_ready && !rx_at_last) rx_asm_d[rx_cnt_q*N +: N] = bsg_in_data;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rx_asm_q <= '0;
      else            rx_asm_q <= rx_asm_d;
    end

    assign enq_word = {bsg_in_data[LW-1:0], rx_asm_q};
  end else begin : g_noasm
    assign enq_word = bsg_in_data[W-1:0];
  end

  always_comb begin
    up_d       = 1'b1;
    rx_cnt_d   = rx_cnt_q;
    fifo_d     = fifo_q;
    fifo_wr_d  = fifo_wr_q ^ enq;
    fifo_rd_d  = fifo_rd_q ^ deq;
    fifo_cnt_d = fifo_cnt_q;
    rx_words_d = rx_words_q;
    if (rx_ready) rx_cnt_d = rx_at_last ? '0 : rx_cnt_q + 1'b1;
    if (enq) fifo_d[fifo_wr_q] = enq_word;
    case ({enq, deq})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (deq) rx_words_d = rx_words_q + 1'b1;
  end

  // TX control
  logic          wide_ready, tx_fire, tx_last, wide_acc;
  logic [RN-1:0] word_in;

  assign wide_ready = up_q & (tx_state_q != TX_BOTH);
  assign tx_fire    = (tx_state_q != TX_EMPTY) & peer_ready;
  assign tx_last    = tx_fire & (tx_cnt_q == LAST);
  assign wide_acc   = wide_in_v & wide_ready;
  assign word_in    = RN'(wide_in_data);

  always_comb begin
    tx_state_d = tx_state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    tx_cnt_d   = tx_cnt_q;
    tx_words_d = tx_words_q;
    if (tx_fire) tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
    if (tx_last) tx_words_d = tx_words_q + 1'b1;
    case (tx_state_q)
      TX_EMPTY: begin
        if (wide_acc) begin
          active_d   = word_in;
          tx_state_d = TX_ACTIVE;
        end
      end
      TX_ACTIVE: begin
        // A word arriving while the last beat leaves goes straight to ACTIVE,
        // which is what keeps back-to-back words free of idle beats.
        if (tx_last) begin
          if (wide_acc) active_d = word_in;
          else          tx_state_d = TX_EMPTY;
        end else if (wide_acc) begin
          pending_d  = word_in;
          tx_state_d = TX_BOTH;
        end
      end
      TX_BOTH: begin
        if (tx_last) begin
          active_d   = pending_q;
          tx_state_d = TX_ACTIVE;
        end
      end
      default: tx_state_d = TX_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      up_q       <= 1'b0;
      rx_cnt_q   <= '0;
      fifo_q     <= '{default: '0};
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= '0;
      rx_words_q <= '0;
      tx_state_q <= TX_EMPTY;
      active_q   <= '0;
      pending_q  <= '0;
      tx_cnt_q   <= '0;
      tx_words_q <= '0;
    end else begin
      up_q       <= up_d;
      rx_cnt_q   <= rx_cnt_d;
      fifo_q     <= fifo_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      rx_words_q <= rx_words_d;
      tx_state_q <= tx_state_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_words_q <= tx_words_d;
    end
  end

  assign wide_link_o = {fifo_cnt_q != 2'd0, fifo_q[fifo_rd_q], wide_ready};
  assign bsg_link_o  = {tx_state_q != TX_EMPTY, active_q[tx_cnt_q*N +: N], rx_ready};
  assign rx_words_o  = rx_words_q;
  assign tx_words_o  = tx_words_q;

endmodule

// File: tb/tb_bsg_then_ready_link_to_wide_link_db.sv
// Bench for bsg_then_ready_link_to_wide_link_db with W=72, N=16 (R=5, one
// padded byte in the last beat) and 4-bit word counters so wrap is reachable.
module tb_bsg_then_ready_link_to_wide_link_db;

  localparam int W = 72;
  localparam int N = 16;
  localparam int R = 5;
  localparam int CWID = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         wide_v = 1'b0, wide_rdy = 1'b0;
  logic [W-1:0] wide_data = '0;
  logic         bsg_v = 1'b0, peer_rdy_reg = 1'b0, tie = 1'b0;
  logic [N-1:0] bsg_data = '0;
  logic         peer_rdy;
  logic [W+1:0] wide_i, wide_o;
  logic [N+1:0] bsg_i, bsg_o;
  logic [CWID-1:0] rxw, txw;

  logic         o_wv, o_wr, o_bv, o_btr;
  logic [W-1:0] o_wd;
  logic [N-1:0] o_bd;

  // In tie mode the serial receiver accepts every beat it is offered.
  assign peer_rdy = tie ? o_bv : peer_rdy_reg;
  assign wide_i   = {wide_v, wide_data, wide_rdy};
  assign bsg_i    = {bsg_v, bsg_data, peer_rdy};
  assign o_wv  = wide_o[W+1];
  assign o_wd  = wide_o[W:1];
  assign o_wr  = wide_o[0];
  assign o_bv  = bsg_o[N+1];
  assign o_bd  = bsg_o[N:1];
  assign o_btr = bsg_o[0];

  bsg_then_ready_link_to_wide_link_db #(
    .wide_link_width_p(W),
    .bsg_link_width_p (N),
    .counter_width_p  (CWID)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .wide_link_i(wide_i),
    .wide_link_o(wide_o),
    .bsg_link_i (bsg_i),
    .bsg_link_o (bsg_o),
    .rx_words_o (rxw),
    .tx_words_o (txw)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queues of whole words, a beat index per direction.
  logic [79:0] m_rxq[$];
  logic [79:0] m_txq[$];
  logic [79:0] m_part = '0;
  int m_rxb = 0, m_txb = 0, m_rxw = 0, m_txw = 0;
  bit m_up = 1'b0;

  function automatic bit exp_trr();
    return m_up && bsg_v && (m_rxb < R - 1 || m_rxq.size() < 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc_b, deq, fire, wacc;
    if (!rst_n) begin
      m_rxq.delete();
      m_txq.delete();
      m_part = '0;
      m_rxb = 0; m_txb = 0; m_rxw = 0; m_txw = 0;
      m_up = 1'b0;
    end else begin
      acc_b = exp_trr();
      deq   = (m_rxq.size() > 0) && wide_rdy;
      fire  = (m_txq.size() > 0) && peer_rdy;
      wacc  = wide_v && m_up && (m_txq.size() < 2);
      if (deq) begin
        void'(m_rxq.pop_front());
        m_rxw = (m_rxw + 1) % 16;
      end
      if (acc_b) begin
        m_part[m_rxb*N +: N] = bsg_data;
        if (m_rxb == R - 1) begin
          m_rxq.push_back({8'h00, m_part[W-1:0]});
          m_part = '0;
          m_rxb = 0;
        end else m_rxb++;
      end
      if (fire) begin
        if (m_txb == R - 1) begin
          void'(m_txq.pop_front());
          m_txb = 0;
          m_txw = (m_txw + 1) % 16;
        end else m_txb++;
      end
      if (wacc) m_txq.push_back({8'h00, wide_data});
      m_up = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [79:0] hw;
    if (chk_en) begin
      check("wide_v", 80'(o_wv), 80'(m_rxq.size() > 0));
      if (m_rxq.size() > 0) begin
        hw = m_rxq[0];
        check("wide_data", 80'(o_wd), {8'h00, hw[W-1:0]});
      end
      check("wide_ready", 80'(o_wr), 80'(m_up && m_txq.size() < 2));
      check("bsg_v", 80'(o_bv), 80'(m_txq.size() > 0));
      if (m_txq.size() > 0) begin
        hw = m_txq[0];
        check("bsg_data", 80'(o_bd), 80'(hw[m_txb*N +: N]));
      end
      check("then_ready_rev", 80'(o_btr), 80'(exp_trr()));
      check("rx_words", 80'(rxw), 80'(m_rxw));
      check("tx_words", 80'(txw), 80'(m_txw));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N:0]   samp [12];
  logic [N-1:0] eb   [10];

  initial begin
    // 1. Reset with every input valid asserted
    #2;
    rst_n = 1'b0;
    chk_en = 1'b1;
    wide_v = 1'b1; bsg_v = 1'b1; wide_rdy = 1'b1; peer_rdy_reg = 1'b1;
    wide_data = 72'h1; bsg_data = 16'h1;
    step(); step();
    check("rst_wide_v", 80'(o_wv), 80'd0);
    check("rst_bsg_v", 80'(o_bv), 80'd0);
    check("rst_ready", 80'(o_wr), 80'd0);
    check("rst_trr", 80'(o_btr), 80'd0);
    check("rst_rxw", 80'(rxw), 80'd0);
    check("rst_txw", 80'(txw), 80'd0);
    wide_v = 1'b0; bsg_v = 1'b0; peer_rdy_reg = 1'b0;
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 80'(o_wr), 80'd1);
    check("no_spurious_beat", 80'(o_bv), 80'd0);

    // 2 + 5. RX word, last beat carries junk in the pad byte
    for (int k = 1; k <= 5; k++) begin
      bsg_v = 1'b1;
      bsg_data = (k == 5) ? 16'hFF05 : 16'(k);
      step();
    end
    bsg_v = 1'b0;
    check("rx_word_v", 80'(o_wv), 80'd1);
    check("rx_word_data", 80'(o_wd), 80'h05_0004_0003_0002_0001);
    step();
    check("rx_words_1", 80'(rxw), 80'd1);

    // 3. RX backpressure: two full words buffered, last beat of the third stalls
    wide_rdy = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      bsg_v = 1'b1;
      bsg_data = 16'h0100 + 16'(k);
      step();
    end
    bsg_data = 16'h010F;
    #1;
    check("rx_stall", 80'(o_btr), 80'd0);
    step(); step();
    check("rx_stall_held", 80'(o_btr), 80'd0);
    wide_rdy = 1'b1;
    #1;
    check("rx_head", 80'(o_wd), 80'h05_0104_0103_0102_0101);
    step();
    wide_rdy = 1'b0;
    #1;
    check("rx_unstall", 80'(o_btr), 80'd1);
    step();
    bsg_v = 1'b0;
    wide_rdy = 1'b1;
    step(); step(); step(); step();
    check("rx_words_4", 80'(rxw), 80'd4);
    check("rx_drained", 80'(o_wv), 80'd0);

    // 4 + 5. TX back-to-back words with a receiver that always accepts
    tie = 1'b1;
    eb = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h00AA,
           16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h00BB};
    wide_v = 1'b1;
    wide_data = 72'hAA_0A04_0A03_0A02_0A01;
    step();
    samp[0] = {o_bv, o_bd};
    wide_data = 72'hBB_0B04_0B03_0B02_0B01;
    check("ready_for_b", 80'(o_wr), 80'd1);
    step();
    samp[1] = {o_bv, o_bd};
    check("ready_pending_full", 80'(o_wr), 80'd0);
    wide_v = 1'b0;
    for (int i = 2; i < 12; i++) begin
      step();
      samp[i] = {o_bv, o_bd};
    end
    for (int i = 0; i < 10; i++) check($sformatf("tx_beat%0d", i), 80'(samp[i]), {63'd0, 1'b1, eb[i]});
    check("tx_idle_after", 80'(samp[10][N]), 80'd0);
    check("tx_words_2", 80'(txw), 80'd2);
    tie = 1'b0;

    // 6. Reset mid-word discards partial beats; counter wrap
    for (int k = 1; k <= 3; k++) begin
      bsg_v = 1'b1;
      bsg_data = 16'h0C00 + 16'(k);
      step();
    end
    rst_n = 1'b0;
    bsg_v = 1'b0;
    step();
    check("rst2_rxw", 80'(rxw), 80'd0);
    check("rst2_txw", 80'(txw), 80'd0);
    rst_n = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      bsg_v = 1'b1;
      bsg_data = 16'h0B00 + 16'(k);
      step();
    end
    bsg_v = 1'b0;
    check("fresh_word", 80'(o_wd), 80'h05_0B04_0B03_0B02_0B01);
    step();
    check("fresh_rxw", 80'(rxw), 80'd1);
    for (int w = 0; w < 16; w++) begin
      for (int b = 0; b < 5; b++) begin
        bsg_v = 1'b1;
        bsg_data = 16'(w * 256 + b);
        step();
      end
    end
    bsg_v = 1'b0;
    step(); step();
    check("rx_wrap", 80'(rxw), 80'd1);

    chk_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
